// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counter sequencing controller.
package down_counter_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Sequence mode encodings, as presented on the mode input
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_counter_ctrl_tick_prescaler.sv
// Programmable tick divider: asserts tick combinationally on the cycle where
// the phase counter matches presc while enabled, so a tick occurs every
// presc+1 enabled cycles. The phase holds while enable is low.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] P_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0] p_reg;
  logic [PRESC_W-1:0] p_next;

  assign tick = enable && (p_reg == presc);

  // Next phase: clear wins, wrap on tick, otherwise advance while enabled
  always_comb begin
    p_next = p_reg;
    if (clear) begin
      p_next = '0;
    end else if (enable) begin
      p_next = tick ? '0 : (p_reg + P_ONE);
    end
  end

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
    end else begin
      p_reg <= p_next;
    end
  end

endmodule

// File: rtl/down_counter_ctrl.sv
// Sequencing controller for a down counter: latches a start value, paces
// decrements through a prescaler, and reports terminal count. Supports
// one-shot / auto-reload, pause and abort. All outputs are registered.
module down_counter_ctrl
  import down_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               mode,
  input  logic [PRESC_W-1:0] prescale,
  output logic               start_ack,
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               done
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic [WIDTH-1:0]   load_q_reg, load_q_next;
  logic               mode_q_reg, mode_q_next;
  logic [PRESC_W-1:0] presc_q_reg, presc_q_next;
  logic               start_ack_reg, start_ack_next;
  logic               busy_reg, busy_next;
  logic               tick_reg, tick_next;
  logic               done_reg, done_next;

  logic               presc_clear;
  logic               presc_enable;
  logic               presc_tick;

  // The prescaler only advances in RUN with nothing overriding it; a new
  // sequence or an abort restarts its phase from zero.
  assign presc_enable = (state_reg == RUN) && !pause && !stop;
  assign presc_clear  = stop || ((state_reg == IDLE) && start);

  tick_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (presc_clear),
    .enable (presc_enable),
    .presc  (presc_q_reg),
    .tick   (presc_tick)
  );

  // Next-state and output logic; priority is stop > pause > tick
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    load_q_next    = load_q_reg;
    mode_q_next    = mode_q_reg;
    presc_q_next   = presc_q_reg;
    start_ack_next = 1'b0;
    tick_next      = 1'b0;
    done_next      = 1'b0;

    if (stop) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            load_q_next    = load_val;
            mode_q_next    = mode;
            presc_q_next   = prescale;
            count_next     = load_val;
            start_ack_next = 1'b1;
            state_next     = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (presc_tick) begin
            tick_next = 1'b1;
            if (count_reg != '0) begin
              count_next = count_reg - C_ONE;
            end else begin
              done_next = 1'b1;
              if (mode_q_reg == MODE_ONESHOT) begin
                state_next = IDLE;
                count_next = '0;
              end else begin
                count_next = load_q_reg;
              end
            end
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      load_q_reg    <= '0;
      mode_q_reg    <= MODE_ONESHOT;
      presc_q_reg   <= '0;
      start_ack_reg <= 1'b0;
      busy_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      load_q_reg    <= load_q_next;
      mode_q_reg    <= mode_q_next;
      presc_q_reg   <= presc_q_next;
      start_ack_reg <= start_ack_next;
      busy_reg      <= busy_next;
      tick_reg      <= tick_next;
      done_reg      <= done_next;
    end
  end

  assign start_ack = start_ack_reg;
  assign busy      = busy_reg;
  assign count     = count_reg;
  assign tick      = tick_reg;
  assign done      = done_reg;

endmodule
